regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 5, register address width.
REQ-002 The block SHALL have parameter WORD_SIZE, default 32, register data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have ports a_valid/a_ready, input/output, 1 each, source A (ALU writeback) handshake.
REQ-006 The block SHALL have ports a_addr/a_data, input, ADDR_SIZE/WORD_SIZE, source A destination and value.
REQ-007 The block SHALL have ports b_valid/b_ready, input/output, 1 each, source B (load/mul-div writeback) handshake.
REQ-008 The block SHALL have ports b_addr/b_data, input, ADDR_SIZE/WORD_SIZE, source B destination and value.
REQ-009 The block SHALL have ports d_we/d_addr/d_data, output, 1/ADDR_SIZE/WORD_SIZE, registered drive of the register file write port.
REQ-010 The block SHALL have port conf_cnt, output, 8, saturating count of cycles with both sources valid.

Function
REQ-011 Transfer on a source SHALL occur when its valid and ready are both high at a rising clk edge.
REQ-012 At most one of a_ready, b_ready SHALL be high in any cycle; ready SHALL only be high for a valid source (ready may depend on valid).
REQ-013 With one source valid, that source SHALL be granted that cycle; with none valid, neither ready SHALL be high.
REQ-014 With both valid, the source named by the internal priority bit prio (0 = A, 1 = B) SHALL be granted.
REQ-015 Write latency SHALL be exactly one cycle: a transfer at edge N SHALL present d_we/d_addr/d_data from edge N until edge N+1.
REQ-016 d_we SHALL be 1 after a transfer with nonzero address, and 0 after a cycle with no transfer.
REQ-017 A transfer with address 0 SHALL be accepted (ready high) but SHALL produce d_we = 0; d_addr/d_data still update.
REQ-018 d_addr/d_data SHALL hold their previous value in cycles with no transfer.
REQ-019 Throughput SHALL be one write per cycle; the write port never backpressures.
REQ-020 conf_cnt SHALL increment by 1 on each edge where a_valid and b_valid are both high, saturating at 255.
REQ-021 The block SHALL NOT check that requester addr/data stay stable while valid and not ready; that is the requester's obligation.
REQ-022 Identical destinations from A and B SHALL be serialised in grant order; the later write wins in the register file.

Reset
REQ-023 On an edge with rst_n low: d_we = 0, d_addr = 0, d_data = 0, prio = 0, conf_cnt = 0.
REQ-024 While rst_n is low, a_ready and b_ready SHALL be 0 and no transfer SHALL occur.
REQ-025 Reset asserted mid-stream SHALL discard the pending write; d_we SHALL be 0 from the following edge.
REQ-026 The first edge with rst_n high SHALL accept transfers normally, with A holding priority.

Configuration
REQ-027 Macro WB_RR_EN SHALL select the arbitration policy.
REQ-028 With WB_RR_EN defined, prio SHALL flip to the non-granted source after each transfer that occurs while both sources are valid, and SHALL be unchanged otherwise.
REQ-029 Without WB_RR_EN, prio SHALL stay 0 permanently (fixed priority A over B); all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: reset, then A only, addr 3, data 0xDEADBEEF for 1 cycle -> a_ready = 1; next cycle d_we = 1, d_addr = 3, d_data = 0xDEADBEEF; following cycle d_we = 0.
REQ-031 The bench SHALL cover: B addr 0, data 0x12345678 -> b_ready = 1, d_we = 0 next cycle, d_data = 0x12345678.
REQ-032 The bench SHALL cover: both valid for 4 cycles, A addr 1, B addr 2, with WB_RR_EN -> grants A,B,A,B and conf_cnt = 4; without WB_RR_EN -> grants A,A,A,A and b_ready never high.
REQ-033 The bench SHALL cover: both valid held for 300 cycles -> conf_cnt = 255, no wrap to 0.
REQ-034 The bench SHALL cover: rst_n driven low for 1 cycle during a back-to-back A stream -> d_we = 0 and conf_cnt = 0 the next cycle; readies are 0 during reset; the stream resumes with A granted first.
REQ-035 The bench SHALL cover: A then B to addr 7 with data 0x1 then 0x2 -> two consecutive writes, and a register file read of 7 returns 0x2.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Two-source writeback arbiter driving a single register-file write port (one write per cycle).
// Define WB_RR_EN for round-robin arbitration; the default build uses fixed priority A over B.
module regfile_wb_arb #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_data,
    output logic                 d_we,
    output logic [ADDR_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_data,
    output logic [7:0]           conf_cnt
);

    logic prio;
    logic grant_a;
    logic grant_b;
    logic both_valid;

    assign both_valid = a_valid && b_valid;

    // Readies are gated by reset so nothing is handshaken while the block is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            grant_a = a_valid && (!b_valid || !prio);
            grant_b = b_valid && (!a_valid ||  prio);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_we     <= 1'b0;
            d_addr   <= '0;
            d_data   <= '0;
            prio     <= 1'b0;
            conf_cnt <= 8'd0;
        end else begin
            // Address 0 is accepted but never written, as r0 is hardwired.
            if (grant_a) begin
                d_we   <= (a_addr != '0);
                d_addr <= a_addr;
                d_data <= a_data;
            end else if (grant_b) begin
                d_we   <= (b_addr != '0);
                d_addr <= b_addr;
                d_data <= b_data;
            end else begin
                d_we   <= 1'b0;
            end

            if (both_valid && (conf_cnt != 8'hFF)) begin
                conf_cnt <= conf_cnt + 8'd1;
            end

`ifdef WB_RR_EN
            if (both_valid) begin
                prio <= grant_a;
            end
`else
            prio <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed scenarios plus random traffic against a reference model.
// Honours WB_RR_EN the same way the design does.
module tb_regfile_wb_arb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data;
    logic [7:0]    conf_cnt;

    int vectors;
    int miscompares;

    // reference model state
    bit            m_prio;
    int            m_cnt;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] rf [0:(1<<AW)-1];
    int            b_grants;
    string         last_grants;

    regfile_wb_arb #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .d_we(d_we), .d_addr(d_addr), .d_data(d_data), .conf_cnt(conf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check readies, clock, check the write port.
    task automatic step(input bit r, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit ga, gb;
        @(negedge clk);
        rst_n = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        if (!r)            begin ga = 0; gb = 0; end
        else if (av && bv) begin ga = !m_prio; gb = m_prio; end
        else               begin ga = av; gb = bv; end
        #1;
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        if (b_ready) b_grants++;
        last_grants = {last_grants, ga ? "A" : (gb ? "B" : "-")};
        @(posedge clk);
        #1;
        if (!r) begin
            m_prio = 0; m_cnt = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            if (ga)      begin m_we = (aa != 0); m_addr = aa; m_data = ad; end
            else if (gb) begin m_we = (ba != 0); m_addr = ba; m_data = bd; end
            else         m_we = 0;
            if (av && bv) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
`ifdef WB_RR_EN
                m_prio = ga;
`endif
            end
        end
        chk("d_we", d_we, m_we);
        chk("d_addr", d_addr, m_addr);
        chk("d_data", d_data, m_data);
        chk("conf_cnt", conf_cnt, m_cnt);
        if (d_we === 1'b1) rf[d_addr] = d_data;
    endtask

    task automatic idle();
        step(1, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; b_grants = 0; last_grants = "";
        m_prio = 0; m_cnt = 0; m_we = 0; m_addr = '0; m_data = '0;
        for (int i = 0; i < (1<<AW); i++) rf[i] = '0;
        rst_n = 0; a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

        // reset with both sources requesting: no handshake, no count
        step(0, 1, 5'd4, 32'h1111, 1, 5'd5, 32'h2222);
        step(0, 1, 5'd4, 32'h1111, 1, 5'd5, 32'h2222);
        chk("rst_conf", conf_cnt, 0);
        chk("rst_we", d_we, 0);

        // single A write, then idle holds addr/data
        step(1, 1, 5'd3, 32'hDEADBEEF, 0, '0, '0);
        chk("a3_we", d_we, 1);
        chk("a3_data", d_data, 32'hDEADBEEF);
        idle();
        chk("a3_idle_we", d_we, 0);
        chk("a3_hold_addr", d_addr, 3);

        // B to address 0: accepted, not written
        step(1, 0, '0, '0, 1, 5'd0, 32'h12345678);
        chk("b0_we", d_we, 0);
        chk("b0_data", d_data, 32'h12345678);
        idle();

        // four cycles of contention
        b_grants = 0; last_grants = "";
        for (int i = 0; i < 4; i++) step(1, 1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i);
        chk("conf4", conf_cnt, 4);
`ifdef WB_RR_EN
        assert (last_grants == "ABAB") else begin
            miscompares++; $error("FAIL rr_order: got %s want ABAB", last_grants);
        end
`else
        chk("fixed_b_grants", b_grants, 0);
`endif
        vectors++;
        idle();

        // same destination from A then B: later write wins
        step(1, 1, 5'd7, 32'h1, 0, '0, '0);
        chk("w7a_we", d_we, 1);
        step(1, 0, '0, '0, 1, 5'd7, 32'h2);
        chk("w7b_we", d_we, 1);
        chk("rf7", rf[7], 32'h2);
        idle();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                    1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
        idle();

        // long contention saturates the counter
        for (int i = 0; i < 300; i++) step(1, 1, AW'(i), i, 1, AW'(i + 1), ~i);
        chk("conf_sat", conf_cnt, 255);

        // reset in the middle of an A stream, then resume with contention
        for (int i = 0; i < 3; i++) step(1, 1, 5'd9, 32'h900 + i, 0, '0, '0);
        step(0, 1, 5'd9, 32'h903, 0, '0, '0);
        chk("midrst_we", d_we, 0);
        chk("midrst_conf", conf_cnt, 0);
        last_grants = "";
        step(1, 1, 5'd10, 32'hA10, 1, 5'd11, 32'hB11);
        chk("resume_we", d_we, 1);
        chk("resume_addr", d_addr, 10);
        assert (last_grants == "A") else begin
            miscompares++; $error("FAIL resume_grant: got %s want A", last_grants);
        end
        vectors++;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
